// File: rtl/mod_counter.sv
// mod_counter: parametrised up/down modulo counter.
// Counts over 0..MOD-1 with runtime direction, parallel load, wrap or
// saturate at the terminal value, a zero-latency carry for cascading and a
// sticky overflow flag. Stages chain by tying the next stage's en to this
// stage's carry.
module mod_counter #(
  parameter int unsigned      WIDTH    = 4,
  parameter longint unsigned  MOD      = 10,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up,
  output logic [WIDTH-1:0] cnt_value,
  output logic             carry,
  output logic             ovf
);

  // The modulus needs one bit more than the counter when MOD == 2**WIDTH,
  // so it is only ever compared in WIDTH+1 bits.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] cnt_q;
  logic             ovf_q;
  logic [WIDTH-1:0] term_val;
  logic             at_term;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_clamped;
  logic             step_now;

  // Terminal value follows the direction sampled this cycle.
  always_comb begin
    term_val = '0;
    if (up) begin
      term_val = MAX_VAL;
    end
    at_term = (cnt_q == term_val);
  end

  // Next value for an enabled step; the non-terminal +/-1 can never leave
  // the range, so plain WIDTH-bit arithmetic is exact there.
  always_comb begin
    step_val = cnt_q;
    if (at_term) begin
      if (SATURATE) begin
        step_val = cnt_q;
      end else if (up) begin
        step_val = '0;
      end else begin
        step_val = MAX_VAL;
      end
    end else if (up) begin
      step_val = cnt_q + WIDTH'(1);
    end else begin
      step_val = cnt_q - WIDTH'(1);
    end
  end

  // Out-of-range load values clamp to the top of the range.
  always_comb begin
    load_clamped = MAX_VAL;
    if ({1'b0, load_value} < MOD_EXT) begin
      load_clamped = load_value;
    end
  end

  assign step_now = en & ~clr & ~load;

  // Count and sticky-overflow registers; clr > load > en > hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (load) begin
      cnt_q <= load_clamped;
    end else if (en) begin
      cnt_q <= step_val;
      if (at_term) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Carry is combinational so a following stage steps on the same edge.
  assign carry     = rst & step_now & at_term;
  assign cnt_value = cnt_q;
  assign ovf       = ovf_q;

endmodule
